// File: rtl/fp128_unpack_norm.sv
// Unpacks an IEEE-754 binary128 operand into the internal FP128 format:
// explicit leading one, widened signed exponent, class flags; subnormals normalized iteratively.
module fp128_unpack_norm #(
    parameter int CSHIFT = 16,
    parameter int XW     = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [127:0]  i,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_sign,
    output logic [XW-1:0] o_exp,
    output logic [112:0]  o_sig,
    output logic          o_zero,
    output logic          o_sub,
    output logic          o_inf,
    output logic          o_qnan,
    output logic          o_snan
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    localparam int LZW = $clog2(CSHIFT);

    state_t          state;
    logic [14:0]     in_exp;
    logic [111:0]    in_frac;
    logic            accept;
    logic            top_zero;
    logic [LZW-1:0]  lz;
    logic            lz_found;

    assign in_exp   = i[126:112];
    assign in_frac  = i[111:0];
    assign i_ready  = (state == IDLE) | ((state == DONE) & o_ready);
    assign accept   = i_valid & i_ready;
    assign o_valid  = (state == DONE);
    assign top_zero = (o_sig[112 -: CSHIFT] == '0);

    // Leading-zero count of the top CSHIFT bits; only used when that field is nonzero.
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int b = 0; b < CSHIFT; b++) begin
            if (!lz_found && o_sig[112-b]) begin
                lz       = LZW'(b);
                lz_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            o_sign <= 1'b0;
            o_exp  <= '0;
            o_sig  <= '0;
            o_zero <= 1'b0;
            o_sub  <= 1'b0;
            o_inf  <= 1'b0;
            o_qnan <= 1'b0;
            o_snan <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        o_sign <= i[127];
                        o_zero <= 1'b0;
                        o_sub  <= 1'b0;
                        o_inf  <= 1'b0;
                        o_qnan <= 1'b0;
                        o_snan <= 1'b0;
                        state  <= DONE;
                        if (in_exp == 15'h7fff) begin
                            o_exp <= XW'(in_exp);
                            if (in_frac == '0) begin
                                o_inf <= 1'b1;
                                o_sig <= {1'b1, in_frac};
                            end else begin
                                o_qnan <= in_frac[111];
                                o_snan <= ~in_frac[111];
                                o_sig  <= {1'b0, in_frac};
                            end
                        end else if (in_exp != '0) begin
                            o_exp <= XW'(in_exp);
                            o_sig <= {1'b1, in_frac};
                        end else if (in_frac == '0) begin
                            o_zero <= 1'b1;
                            o_exp  <= '0;
                            o_sig  <= '0;
                        end else begin
                            // Subnormal: implicit exponent is 1, shift toward bit 112 in NORM.
                            o_sub <= 1'b1;
                            o_exp <= XW'(1);
                            o_sig <= {1'b0, in_frac};
                            state <= NORM;
                        end
                    end else if (state == DONE && o_ready) begin
                        state <= IDLE;
                    end
                end
                NORM: begin
                    if (top_zero) begin
                        o_sig <= o_sig << CSHIFT;
                        o_exp <= o_exp - XW'(CSHIFT);
                    end else begin
                        o_sig <= o_sig << lz;
                        o_exp <= o_exp - XW'(lz);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp128_unpack_norm.sv
// Self-checking bench for fp128_unpack_norm: reference model feeds a scoreboard queue.
module tb_fp128_unpack_norm;
    logic          clk = 1'b0;
    logic          rst, ce, i_valid, o_ready;
    logic [127:0]  i;
    logic          i_ready, o_valid, o_sign;
    logic [16:0]   o_exp;
    logic [112:0]  o_sig;
    logic          o_zero, o_sub, o_inf, o_qnan, o_snan;
    logic [4:0]    flags;

    assign flags = {o_zero, o_sub, o_inf, o_qnan, o_snan};

    fp128_unpack_norm #(.CSHIFT(16), .XW(17)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .i_valid(i_valid), .i_ready(i_ready), .i(i),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig),
        .o_zero(o_zero), .o_sub(o_sub), .o_inf(o_inf), .o_qnan(o_qnan), .o_snan(o_snan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sign;
        logic [16:0]  exp;
        logic [112:0] sig;
        logic [4:0]   fl;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t model(input logic [127:0] v);
        exp_t         r;
        logic [14:0]  e;
        logic [111:0] f;
        logic [112:0] w;
        int           L;
        r      = '0;
        r.sign = v[127];
        e      = v[126:112];
        f      = v[111:0];
        r.lat  = 1;
        if (e == 15'h7fff) begin
            r.exp = 17'h07fff;
            if (f == '0) begin
                r.sig = {1'b1, f};
                r.fl  = 5'b00100;
            end else begin
                r.sig = {1'b0, f};
                r.fl  = f[111] ? 5'b00010 : 5'b00001;
            end
        end else if (e == '0 && f == '0) begin
            r.fl = 5'b10000;
        end else if (e != '0) begin
            r.exp = {2'b00, e};
            r.sig = {1'b1, f};
        end else begin
            w = {1'b0, f};
            L = 0;
            while (!w[112]) begin
                w = w << 1;
                L++;
            end
            r.sig = w;
            r.exp = 17'(1 - L);
            r.fl  = 5'b01000;
            r.lat = 2 + L / 16;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({o_valid, i_ready, o_sign, o_exp, o_sig, flags} !== {1'b0, 1'b1, 1'b0, 17'h0, 113'h0, 5'h0}) begin
            fails++;
            $display("FAIL reset: got v=%b r=%b s=%b e=%h sig=%h fl=%b, want v=0 r=1 all zero",
                     o_valid, i_ready, o_sign, o_exp, o_sig, flags);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_ops();
        logic [127:0] ops [12];
        exp_t         e;
        int           cyc;
        ops[0]  = 128'h3fff_0000_0000_0000_0000_0000_0000_0000;
        ops[1]  = 128'h1;
        ops[2]  = 128'h0000_8000_0000_0000_0000_0000_0000_0000;
        ops[3]  = 128'hffff_0000_0000_0000_0000_0000_0000_0000;
        ops[4]  = 128'h7fff_8000_0000_0000_0000_0000_0000_0000;
        ops[5]  = 128'h7fff_0000_0000_0000_0000_0000_0000_0001;
        ops[6]  = 128'h0;
        ops[7]  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        ops[8]  = 128'h1 << 96;
        ops[9]  = 128'h1 << 97;
        ops[10] = 128'h1 << 95;
        ops[11] = {16'h8000, 16'h0, 32'h0, $urandom_range(1, 32'hffff_ffff), 32'h0};
        o_ready = 1'b1;
        foreach (ops[k]) begin
            i = ops[k];
            i_valid = 1'b1;
            sb.push_back(model(ops[k]));
            tests++;
            if (i_ready !== 1'b1) begin
                fails++;
                $display("FAIL idle_ready op%0d: got %b want 1", k, i_ready);
            end
            @(posedge clk); #1;
            i_valid = 1'b0;
            i = '0;
            cyc = 1;
            while (o_valid !== 1'b1 && cyc < 50) begin
                tests++;
                if (i_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL norm_ready op%0d cyc%0d: got %b want 0", k, cyc, i_ready);
                end
                @(posedge clk); #1;
                cyc++;
            end
            e = sb.pop_front();
            tests++;
            if (o_valid !== 1'b1 || cyc != e.lat) begin
                fails++;
                $display("FAIL latency op%0d: got %0d (valid=%b) want %0d", k, cyc, o_valid, e.lat);
            end
            tests++;
            if ({o_sign, o_exp, o_sig, flags} !== {e.sign, e.exp, e.sig, e.fl}) begin
                fails++;
                $display("FAIL result op%0d: got s=%b e=%h sig=%h fl=%b want s=%b e=%h sig=%h fl=%b",
                         k, o_sign, o_exp, o_sig, flags, e.sign, e.exp, e.sig, e.fl);
            end
            @(posedge clk); #1;
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL drain op%0d: o_valid got %b want 0", k, o_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] op;
        exp_t         e, last;
        o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = {$urandom_range(0, 1) == 1, 15'($urandom_range(1, 32'h7ffe)),
                  16'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            i = op;
            i_valid = 1'b1;
            sb.push_back(model(op));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (o_valid !== 1'b1 || {o_sign, o_exp, o_sig, flags} !== {e.sign, e.exp, e.sig, e.fl}) begin
                fails++;
                $display("FAIL stream%0d: got v=%b e=%h sig=%h want v=1 e=%h sig=%h",
                         k, o_valid, o_exp, o_sig, e.exp, e.sig);
            end
            last = e;
        end
        // Hold a fifth operand while downstream stalls; it must not be taken early.
        op = 128'hc000_1234_0000_0000_0000_0000_0000_0000;
        i = op;
        o_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (i_ready !== 1'b0 || o_valid !== 1'b1 ||
                {o_sign, o_exp, o_sig, flags} !== {last.sign, last.exp, last.sig, last.fl}) begin
                fails++;
                $display("FAIL stall%0d: got r=%b v=%b e=%h sig=%h want r=0 v=1 e=%h sig=%h",
                         k, i_ready, o_valid, o_exp, o_sig, last.exp, last.sig);
            end
            @(posedge clk); #1;
        end
        sb.push_back(model(op));
        o_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        e = sb.pop_front();
        tests++;
        if (o_valid !== 1'b1 || {o_sign, o_exp, o_sig, flags} !== {e.sign, e.exp, e.sig, e.fl}) begin
            fails++;
            $display("FAIL after_stall: got v=%b e=%h sig=%h want v=1 e=%h sig=%h",
                     o_valid, o_exp, o_sig, e.exp, e.sig);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_norm();
        exp_t e;
        o_ready = 1'b1;
        i = 128'h1;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_pre%0d: o_valid got %b want 0", k, o_valid);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({o_valid, i_ready, o_sign, o_exp, o_sig, flags} !== {1'b0, 1'b1, 1'b0, 17'h0, 113'h0, 5'h0}) begin
            fails++;
            $display("FAIL rst_mid: got v=%b r=%b e=%h sig=%h fl=%b want v=0 r=1 all zero",
                     o_valid, i_ready, o_exp, o_sig, flags);
        end
        repeat (10) begin
            @(posedge clk); #1;
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_drop: o_valid got %b want 0", o_valid);
            end
        end
        i = 128'h3fff_0000_0000_0000_0000_0000_0000_0000;
        i_valid = 1'b1;
        sb.push_back(model(i));
        @(posedge clk); #1;
        i_valid = 1'b0;
        e = sb.pop_front();
        tests++;
        if (o_valid !== 1'b1 || {o_sign, o_exp, o_sig, flags} !== {e.sign, e.exp, e.sig, e.fl}) begin
            fails++;
            $display("FAIL rst_recover: got v=%b e=%h sig=%h fl=%b want v=1 e=%h sig=%h fl=%b",
                     o_valid, o_exp, o_sig, flags, e.exp, e.sig, e.fl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ce_stall();
        exp_t e;
        int   cyc;
        o_ready = 1'b1;
        i = 128'h1;
        i_valid = 1'b1;
        sb.push_back(model(i));
        @(posedge clk); #1;
        i_valid = 1'b0;
        cyc = 1;
        ce = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            cyc++;
            tests++;
            if (o_valid !== 1'b0 || i_ready !== 1'b0) begin
                fails++;
                $display("FAIL ce_norm: got v=%b r=%b want v=0 r=0", o_valid, i_ready);
            end
        end
        ce = 1'b1;
        while (o_valid !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        tests++;
        if (o_valid !== 1'b1 || cyc != e.lat + 3) begin
            fails++;
            $display("FAIL ce_latency: got %0d (valid=%b) want %0d", cyc, o_valid, e.lat + 3);
        end
        tests++;
        if ({o_sign, o_exp, o_sig, flags} !== {e.sign, e.exp, e.sig, e.fl}) begin
            fails++;
            $display("FAIL ce_result: got e=%h sig=%h fl=%b want e=%h sig=%h fl=%b",
                     o_exp, o_sig, flags, e.exp, e.sig, e.fl);
        end
        // ce low in DONE must keep the result even with o_ready high.
        ce = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b1 || o_exp !== e.exp) begin
            fails++;
            $display("FAIL ce_done: got v=%b e=%h want v=1 e=%h", o_valid, o_exp, e.exp);
        end
        ce = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL ce_drain: o_valid got %b want 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_rst_mid_norm();
        test_ce_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
